// File: rtl/seq_det_pkg.sv
// Helpers for the parametrised serial-pattern detector. These are elaboration-time
// pattern/KMP table builders plus the saturating counter step.
package seq_det_pkg;

  localparam int unsigned MAX_PAT_LEN = 16;

  // Bit k of the pattern, counted from the first-received bit (the MSB).
  function automatic logic pat_bit(input logic [15:0] pat, input int unsigned len,
                                   input int unsigned k);
    return pat[4'(len - 1 - k)];
  endfunction

  // Next matched-prefix length after accepting x with k pattern bits already matched.
  // Longest pattern prefix (up to len) that is a suffix of (first k pattern bits, x).
  function automatic int unsigned kmp_next(input logic [15:0] pat, input int unsigned len,
                                           input int unsigned k, input logic x);
    logic [MAX_PAT_LEN:0] s;
    int unsigned          top;
    int unsigned          res;
    logic                 ok;
    s = '0;
    for (int unsigned m = 0; m < k; m++) s[5'(m)] = pat_bit(pat, len, m);
    s[5'(k)] = x;
    top = (k + 1 < len) ? k + 1 : len;
    res = 0;
    for (int unsigned j = 1; j <= top; j++) begin
      ok = 1'b1;
      for (int unsigned i = 0; i < j; i++)
        if (pat_bit(pat, len, i) != s[5'(k + 1 - j + i)]) ok = 1'b0;
      if (ok) res = j;
    end
    return res;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = 32'hFFFF_FFFF >> (32 - w);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/seq_detector_fsm.sv
// Moore serial-pattern detector: state is the matched-prefix length, next state comes
// from a KMP transition table built at elaboration; saturating match counter.
module seq_detector_fsm
  import seq_det_pkg::*;
#(
  parameter int unsigned          PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1011,
  parameter bit                   OVERLAP = 1'b1,
  parameter int unsigned          CNT_W   = 8,
  parameter int unsigned          ST_W    = $clog2(PAT_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             x,
  input  logic             x_valid,
  input  logic             clr_count,
  output logic             y,
  output logic [ST_W-1:0]  current_state,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [ST_W-1:0] DETECT = ST_W'(PAT_LEN);

  typedef logic [1:0][PAT_LEN:0][ST_W-1:0] tbl_t;

  // Non-overlapping mode restarts from an empty history once DETECT is left.
  function automatic tbl_t build_tbl();
    tbl_t        t;
    logic [15:0] pat;
    pat = 16'(PATTERN);
    t   = '0;
    for (int unsigned xb = 0; xb < 2; xb++) begin
      for (int unsigned k = 0; k <= PAT_LEN; k++) begin
        if (k == PAT_LEN && !OVERLAP)
          t[xb[0]][ST_W'(k)] = (xb[0] == pat_bit(pat, PAT_LEN, 0)) ? ST_W'(1) : '0;
        else
          t[xb[0]][ST_W'(k)] = ST_W'(kmp_next(pat, PAT_LEN, k, xb[0]));
      end
    end
    return t;
  endfunction

  localparam tbl_t NEXT_TBL = build_tbl();

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Clear is applied before the increment so a match in the clear cycle reads 1.
  always_comb begin
    state_d = state_q;
    count_d = clr_count ? '0 : count_q;
    if (x_valid) begin
      state_d = NEXT_TBL[x][state_q];
      if (state_d == DETECT) count_d = CNT_W'(sat_inc(32'(count_d), CNT_W));
    end
  end

  assign y             = (state_q == DETECT);
  assign current_state = state_q;
  assign match_count   = count_q;

endmodule

// File: tb/tb_seq_detector_fsm.sv
// Directed bench for seq_detector_fsm: overlap, non-overlap and 2-bit-counter instances
// share one stimulus stream; expectations are hand-computed for PATTERN=1011.
module tb_seq_detector_fsm;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic x = 1'b0;
  logic x_valid = 1'b0;
  logic clr_count = 1'b0;

  logic       y_ov, y_no, y_c2;
  logic [2:0] st_ov, st_no, st_c2;
  logic [7:0] cnt_ov, cnt_no;
  logic [1:0] cnt_c2;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_detector_fsm #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid), .clr_count(clr_count),
    .y(y_ov), .current_state(st_ov), .match_count(cnt_ov));

  seq_detector_fsm #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_no (
    .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid), .clr_count(clr_count),
    .y(y_no), .current_state(st_no), .match_count(cnt_no));

  seq_detector_fsm #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_c2 (
    .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid), .clr_count(clr_count),
    .y(y_c2), .current_state(st_c2), .match_count(cnt_c2));

  typedef struct {
    bit rst;
    bit xb;
    bit v;
    bit clr;
    int st_ov;
    int cnt_ov;
    int st_no;
    int cnt_no;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit xb, bit v, bit clr,
                              int so, int co, int sn, int cn);
    vec_t r;
    r.rst = rst; r.xb = xb; r.v = v; r.clr = clr;
    r.st_ov = so; r.cnt_ov = co; r.st_no = sn; r.cnt_no = cn;
    return r;
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic step(input bit xb, input bit v, input bit clr);
    @(negedge clk);
    x = xb; x_valid = v; clr_count = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; x_valid = 1'b0; clr_count = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    // Test 1 (overlap) / test 2 (non-overlap): stream 1011011
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2, 0, 2, 0));
    tbl.push_back(mk(0, 1, 1, 0, 3, 0, 3, 0));
    tbl.push_back(mk(0, 1, 1, 0, 4, 1, 4, 1));
    tbl.push_back(mk(0, 0, 1, 0, 2, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 3, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 4, 2, 1, 1));
    // Test 3: KMP fallback on 101011
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2, 0, 2, 0));
    tbl.push_back(mk(0, 1, 1, 0, 3, 0, 3, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2, 0, 2, 0));
    tbl.push_back(mk(0, 1, 1, 0, 3, 0, 3, 0));
    tbl.push_back(mk(0, 1, 1, 0, 4, 1, 4, 1));
    // Test 4: 101, valid gap with x toggling, then 1
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2, 0, 2, 0));
    tbl.push_back(mk(0, 1, 1, 0, 3, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3, 0, 3, 0));
    tbl.push_back(mk(0, 1, 0, 0, 3, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3, 0, 3, 0));
    tbl.push_back(mk(0, 1, 1, 0, 4, 1, 4, 1));
    // DETECT persists across an invalid cycle
    tbl.push_back(mk(0, 0, 0, 0, 4, 1, 4, 1));
    // Leaving DETECT with 1,0,1 (same prefix lengths in both modes)
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 2, 1, 2, 1));
    tbl.push_back(mk(0, 1, 1, 0, 3, 1, 3, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) begin
        do_reset();
        check("rst_state_ov", i, int'(st_ov), 0);
        check("rst_count_ov", i, int'(cnt_ov), 0);
        check("rst_y_ov", i, int'(y_ov), 0);
        release_reset();
      end else begin
        step(tbl[i].xb, tbl[i].v, tbl[i].clr);
        check("state_ov", i, int'(st_ov), tbl[i].st_ov);
        check("y_ov", i, int'(y_ov), int'(tbl[i].st_ov == 4));
        check("count_ov", i, int'(cnt_ov), tbl[i].cnt_ov);
        check("state_no", i, int'(st_no), tbl[i].st_no);
        check("y_no", i, int'(y_no), int'(tbl[i].st_no == 4));
        check("count_no", i, int'(cnt_no), tbl[i].cnt_no);
      end
    end

    // Test 5: async reset mid-cycle after 101 (count is 1 going in)
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_state", 0, int'(st_ov), 0);
    check("async_rst_y", 0, int'(y_ov), 0);
    check("async_rst_count", 0, int'(cnt_ov), 0);
    @(posedge clk);
    release_reset();
    step(1'b1, 1'b1, 1'b0);
    check("post_rst_state", 0, int'(st_ov), 1);
    check("post_rst_y", 0, int'(y_ov), 0);
    check("post_rst_count", 0, int'(cnt_ov), 0);

    // Test 6: 2-bit counter saturation and clear-with-match
    do_reset();
    release_reset();
    step(1, 1, 0); step(0, 1, 0); step(1, 1, 0); step(1, 1, 0);
    check("c2_match1", 1, int'(cnt_c2), 1);
    step(0, 1, 0); step(1, 1, 0); step(1, 1, 0);
    check("c2_match2", 2, int'(cnt_c2), 2);
    step(0, 1, 0); step(1, 1, 0); step(1, 1, 0);
    check("c2_match3", 3, int'(cnt_c2), 3);
    step(0, 1, 0); step(1, 1, 0);
    check("c2_pre_match4", 3, int'(cnt_c2), 3);
    step(1, 1, 0);
    check("c2_match4_sat", 4, int'(cnt_c2), 3);
    check("c2_match4_y", 4, int'(y_c2), 1);
    step(0, 1, 0); step(1, 1, 0);
    step(1, 1, 1);
    check("c2_match5_clr", 5, int'(cnt_c2), 1);
    check("c2_match5_state", 5, int'(st_c2), 4);
    step(0, 0, 1);
    check("c2_clr_only", 6, int'(cnt_c2), 0);
    check("c2_clr_y_hold", 6, int'(y_c2), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
